// File: rtl/pcie_flr_responder_if.sv
// FLR handshake bundle: PCIe-side request/completion signals plus the
// function-reset request/quiesce pair toward the port/AFU logic.
interface pcie_flr_responder_if #(
  parameter int NUM_PF   = 4,
  parameter int PF_WIDTH = 2,
  parameter int VF_WIDTH = 11
);
  logic [NUM_PF-1:0]   flr_active_pf;
  logic                flr_rcvd_vf;
  logic [PF_WIDTH-1:0] flr_rcvd_pf_num;
  logic [VF_WIDTH-1:0] flr_rcvd_vf_num;

  logic [NUM_PF-1:0]   flr_completed_pf;
  logic                flr_completed_vf;
  logic [PF_WIDTH-1:0] flr_completed_pf_num;
  logic [VF_WIDTH-1:0] flr_completed_vf_num;

  logic                o_func_rst_valid;
  logic                o_func_rst_vf_active;
  logic [PF_WIDTH-1:0] o_func_rst_pf;
  logic [VF_WIDTH-1:0] o_func_rst_vf;
  logic                i_func_quiesced;

  logic                o_vf_overflow;

  // Responder side
  modport slave (
    input  flr_active_pf, flr_rcvd_vf, flr_rcvd_pf_num, flr_rcvd_vf_num,
    input  i_func_quiesced,
    output flr_completed_pf, flr_completed_vf, flr_completed_pf_num, flr_completed_vf_num,
    output o_func_rst_valid, o_func_rst_vf_active, o_func_rst_pf, o_func_rst_vf,
    output o_vf_overflow
  );

  // PCIe subsystem / port side
  modport master (
    output flr_active_pf, flr_rcvd_vf, flr_rcvd_pf_num, flr_rcvd_vf_num,
    output i_func_quiesced,
    input  flr_completed_pf, flr_completed_vf, flr_completed_pf_num, flr_completed_vf_num,
    input  o_func_rst_valid, o_func_rst_vf_active, o_func_rst_pf, o_func_rst_vf,
    input  o_vf_overflow
  );
endinterface

// File: rtl/pcie_flr_responder.sv
// FLR completion responder: captures PF/VF FLR requests, serialises them through
// a single reset engine and returns the matching completion pulse once quiesced.
module pcie_flr_responder #(
  parameter int NUM_PF          = 4,
  parameter int PF_WIDTH        = 2,
  parameter int VF_WIDTH        = 11,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int VF_FIFO_DEPTH   = 4
) (
  input  logic                 fim_clk,
  input  logic                 fim_rst_n,
  pcie_flr_responder_if.slave  flr
);

  localparam int CNT_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int PTR_W = $clog2(VF_FIFO_DEPTH);
  localparam int ENT_W = PF_WIDTH + VF_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_PF-1:0]   pf_level_reg;
  logic [NUM_PF-1:0]   pf_rise;
  logic [NUM_PF-1:0]   pf_pending_reg;
  logic [NUM_PF-1:0]   pf_pending_next;
  logic [NUM_PF-1:0]   pf_sel_onehot;
  logic [PF_WIDTH-1:0] pf_sel_idx;
  logic                pf_any;

  logic [ENT_W-1:0]    fifo_mem [VF_FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr_reg, rd_ptr_reg;
  logic [ENT_W-1:0]    fifo_head;
  logic                fifo_empty, fifo_full;
  logic                fifo_push, fifo_pop, vf_drop;

  logic [CNT_W-1:0]    cnt_reg;
  logic                load_pf;

  logic                tgt_vf_active_reg;
  logic [PF_WIDTH-1:0] tgt_pf_reg;
  logic [VF_WIDTH-1:0] tgt_vf_reg;
  logic                rst_valid_reg;
  logic [NUM_PF-1:0]   cpl_pf_reg;
  logic                cpl_vf_reg;
  logic [PF_WIDTH-1:0] cpl_pf_num_reg;
  logic [VF_WIDTH-1:0] cpl_vf_num_reg;
  logic                overflow_reg;

  // Only rising edges of the PF FLR-active level raise a request.
  generate
    for (genvar gi = 0; gi < NUM_PF; gi++) begin : g_pf_edge
      assign pf_rise[gi] = flr.flr_active_pf[gi] & ~pf_level_reg[gi];
    end
  endgenerate

  assign pf_any        = |pf_pending_reg;
  assign pf_sel_onehot = pf_pending_reg & (~pf_pending_reg + NUM_PF'(1));

  always_comb begin
    pf_sel_idx = '0;
    for (int i = NUM_PF - 1; i >= 0; i--) begin
      if (pf_pending_reg[i]) pf_sel_idx = PF_WIDTH'(i);
    end
  end

  // A fresh edge on the PF being selected wins over the clear, so it is re-serviced.
  assign pf_pending_next = (pf_pending_reg & ~(load_pf ? pf_sel_onehot : '0)) | pf_rise;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
  assign fifo_push  = flr.flr_rcvd_vf && (!fifo_full || fifo_pop);
  assign vf_drop    = flr.flr_rcvd_vf && fifo_full && !fifo_pop;

  always_ff @(posedge fim_clk or negedge fim_rst_n) begin
    if (!fim_rst_n) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_pf    = 1'b0;
    fifo_pop   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pf_any) begin
          load_pf    = 1'b1;
          state_next = ST_RESET;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_RESET;
        end
      end
      ST_RESET: begin
        if (cnt_reg == CNT_W'(RST_HOLD_CYCLES - 1)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (flr.i_func_quiesced) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Queue storage carries no reset; entries are only read when the pointers say valid.
  always_ff @(posedge fim_clk) begin
    if (fifo_push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {flr.flr_rcvd_pf_num, flr.flr_rcvd_vf_num};
  end

  always_ff @(posedge fim_clk or negedge fim_rst_n) begin
    if (!fim_rst_n) begin
      pf_level_reg      <= '0;
      pf_pending_reg    <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      cnt_reg           <= '0;
      tgt_vf_active_reg <= 1'b0;
      tgt_pf_reg        <= '0;
      tgt_vf_reg        <= '0;
      rst_valid_reg     <= 1'b0;
      cpl_pf_reg        <= '0;
      cpl_vf_reg        <= 1'b0;
      cpl_pf_num_reg    <= '0;
      cpl_vf_num_reg    <= '0;
      overflow_reg      <= 1'b0;
    end else begin
      pf_level_reg   <= flr.flr_active_pf;
      pf_pending_reg <= pf_pending_next;

      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

      if (state_reg == ST_RESET) cnt_reg <= cnt_reg + 1'b1;
      else                       cnt_reg <= '0;

      if (load_pf) begin
        tgt_vf_active_reg <= 1'b0;
        tgt_pf_reg        <= pf_sel_idx;
        tgt_vf_reg        <= '0;
      end else if (fifo_pop) begin
        tgt_vf_active_reg       <= 1'b1;
        {tgt_pf_reg, tgt_vf_reg} <= fifo_head;
      end

      rst_valid_reg <= (state_next == ST_RESET) || (state_next == ST_DRAIN);

      // Target registers are stable in DRAIN, so the completion is built from them directly.
      if (state_next == ST_DONE && !tgt_vf_active_reg) cpl_pf_reg <= NUM_PF'(1) << tgt_pf_reg;
      else                                              cpl_pf_reg <= '0;

      if (state_next == ST_DONE && tgt_vf_active_reg) begin
        cpl_vf_reg     <= 1'b1;
        cpl_pf_num_reg <= tgt_pf_reg;
        cpl_vf_num_reg <= tgt_vf_reg;
      end else begin
        cpl_vf_reg     <= 1'b0;
        cpl_pf_num_reg <= '0;
        cpl_vf_num_reg <= '0;
      end

      if (vf_drop) overflow_reg <= 1'b1;
    end
  end

  assign flr.o_func_rst_valid     = rst_valid_reg;
  assign flr.o_func_rst_vf_active = tgt_vf_active_reg;
  assign flr.o_func_rst_pf        = tgt_pf_reg;
  assign flr.o_func_rst_vf        = tgt_vf_reg;
  assign flr.flr_completed_pf     = cpl_pf_reg;
  assign flr.flr_completed_vf     = cpl_vf_reg;
  assign flr.flr_completed_pf_num = cpl_pf_num_reg;
  assign flr.flr_completed_vf_num = cpl_vf_num_reg;
  assign flr.o_vf_overflow        = overflow_reg;

endmodule

// File: tb/tb_pcie_flr_responder.sv
// Directed bench for pcie_flr_responder: completion events are logged with
// cycle stamps relative to the request cycle and compared to hand-derived values.
module tb_pcie_flr_responder;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   t0  = 0;
  int   n_asserts = 0;
  int   n_fail    = 0;

  typedef struct {
    logic [17:0] val;
    int          cyc;
  } ev_t;
  ev_t evq[$];

  pcie_flr_responder_if #(.NUM_PF(4), .PF_WIDTH(2), .VF_WIDTH(11)) bus ();

  pcie_flr_responder #(
    .NUM_PF(4), .PF_WIDTH(2), .VF_WIDTH(11), .RST_HOLD_CYCLES(16), .VF_FIFO_DEPTH(4)
  ) dut (
    .fim_clk   (clk),
    .fim_rst_n (rst_n),
    .flr       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  function automatic logic [17:0] pack(input logic [3:0] pf, input logic vf,
                                       input logic [1:0] pfn, input logic [10:0] vfn);
    return {pf, vf, pfn, vfn};
  endfunction

  task automatic goto(input int c);
    while (cyc - t0 < c) @(negedge clk);
  endtask

  task automatic chk_ev(input string tag, input int idx, input logic [17:0] exp, input int exp_cyc);
    if (idx < evq.size()) begin
      check({tag, "_val"}, 32'(evq[idx].val), 32'(exp));
      check({tag, "_cyc"}, evq[idx].cyc - t0, exp_cyc);
    end else begin
      check({tag, "_missing"}, evq.size(), idx + 1);
    end
  endtask

  // Log every completion; completion numbers must be zero whenever no VF completes.
  always @(negedge clk) begin
    if (bus.flr_completed_pf != 4'b0 || bus.flr_completed_vf) begin
      evq.push_back('{val: pack(bus.flr_completed_pf, bus.flr_completed_vf,
                                bus.flr_completed_pf_num, bus.flr_completed_vf_num),
                      cyc: cyc});
      check("done_valid_low", bus.o_func_rst_valid, 0);
    end
    if (!bus.flr_completed_vf)
      check("cpl_num_idle", {bus.flr_completed_pf_num, bus.flr_completed_vf_num}, 0);
  end

  initial begin
    rst_n = 1'b0;
    bus.flr_active_pf   = '0;
    bus.flr_rcvd_vf     = 1'b0;
    bus.flr_rcvd_pf_num = '0;
    bus.flr_rcvd_vf_num = '0;
    bus.i_func_quiesced = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", bus.o_func_rst_valid, 0);
    check("rst_tgt", {bus.o_func_rst_vf_active, bus.o_func_rst_pf, bus.o_func_rst_vf}, 0);
    check("rst_cpl", {bus.flr_completed_pf, bus.flr_completed_vf}, 0);
    check("rst_ovf", bus.o_vf_overflow, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // PF2 request, quiesce already high
    evq.delete();
    bus.i_func_quiesced = 1'b1;
    bus.flr_active_pf   = 4'b0100;
    t0 = cyc;
    goto(1);  check("pf2_valid_c1", bus.o_func_rst_valid, 0);
    goto(2);  check("pf2_valid_c2", bus.o_func_rst_valid, 1);
    check("pf2_tgt", {bus.o_func_rst_vf_active, bus.o_func_rst_pf, bus.o_func_rst_vf}, {1'b0, 2'd2, 11'd0});
    goto(10); bus.flr_active_pf = 4'b0000;
    goto(18); check("pf2_valid_c18", bus.o_func_rst_valid, 1);
    goto(19); check("pf2_valid_c19", bus.o_func_rst_valid, 0);
    goto(24);
    check("pf2_count", evq.size(), 1);
    chk_ev("pf2_cpl", 0, pack(4'b0100, 1'b0, 2'd0, 11'd0), 19);

    // VF request with delayed quiesce
    evq.delete();
    bus.i_func_quiesced = 1'b0;
    bus.flr_rcvd_vf     = 1'b1;
    bus.flr_rcvd_pf_num = 2'd1;
    bus.flr_rcvd_vf_num = 11'h2A;
    t0 = cyc;
    goto(1);
    bus.flr_rcvd_vf     = 1'b0;
    bus.flr_rcvd_pf_num = '0;
    bus.flr_rcvd_vf_num = '0;
    goto(20);
    check("vf_valid_c20", bus.o_func_rst_valid, 1);
    check("vf_tgt", {bus.o_func_rst_vf_active, bus.o_func_rst_pf, bus.o_func_rst_vf}, {1'b1, 2'd1, 11'h2A});
    goto(40);
    check("vf_valid_c40", bus.o_func_rst_valid, 1);
    bus.i_func_quiesced = 1'b1;
    goto(41); check("vf_valid_c41", bus.o_func_rst_valid, 0);
    goto(45);
    check("vf_count", evq.size(), 1);
    chk_ev("vf_cpl", 0, pack(4'b0000, 1'b1, 2'd1, 11'h2A), 41);

    // Priority: PF1, PF3 and a VF arrive together
    evq.delete();
    bus.flr_rcvd_vf     = 1'b1;
    bus.flr_rcvd_pf_num = 2'd0;
    bus.flr_rcvd_vf_num = 11'd5;
    bus.flr_active_pf   = 4'b1010;
    t0 = cyc;
    goto(1);
    bus.flr_rcvd_vf     = 1'b0;
    bus.flr_rcvd_vf_num = '0;
    goto(62);
    check("prio_count", evq.size(), 3);
    chk_ev("prio_pf1", 0, pack(4'b0010, 1'b0, 2'd0, 11'd0), 19);
    chk_ev("prio_pf3", 1, pack(4'b1000, 1'b0, 2'd0, 11'd0), 38);
    chk_ev("prio_vf5", 2, pack(4'b0000, 1'b1, 2'd0, 11'd5), 57);
    bus.flr_active_pf = 4'b0000;
    goto(64);

    // FIFO overflow: six VF pulses while PF0 is in service
    evq.delete();
    check("ovf_before", bus.o_vf_overflow, 0);
    bus.flr_active_pf = 4'b0001;
    t0 = cyc;
    for (int i = 1; i <= 6; i++) begin
      goto(i);
      bus.flr_rcvd_vf     = 1'b1;
      bus.flr_rcvd_pf_num = 2'd2;
      bus.flr_rcvd_vf_num = 11'(16 + i - 1);
    end
    goto(7);
    bus.flr_rcvd_vf     = 1'b0;
    bus.flr_rcvd_pf_num = '0;
    bus.flr_rcvd_vf_num = '0;
    check("ovf_set", bus.o_vf_overflow, 1);
    goto(10); bus.flr_active_pf = 4'b0000;
    goto(100);
    check("ovf_count", evq.size(), 5);
    chk_ev("ovf_pf0", 0, pack(4'b0001, 1'b0, 2'd0, 11'd0), 19);
    for (int i = 0; i < 4; i++)
      chk_ev($sformatf("ovf_vf%0d", i), i + 1, pack(4'b0000, 1'b1, 2'd2, 11'(16 + i)), 38 + 19 * i);
    check("ovf_held", bus.o_vf_overflow, 1);

    // Reset during DRAIN abandons the FLR
    evq.delete();
    bus.i_func_quiesced = 1'b0;
    bus.flr_active_pf   = 4'b1000;
    t0 = cyc;
    goto(20);
    check("mid_valid_drain", bus.o_func_rst_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_valid_rst", bus.o_func_rst_valid, 0);
    check("mid_tgt_rst", {bus.o_func_rst_vf_active, bus.o_func_rst_pf, bus.o_func_rst_vf}, 0);
    check("mid_ovf_rst", bus.o_vf_overflow, 0);
    bus.flr_active_pf = 4'b0000;
    goto(23);
    rst_n = 1'b1;
    bus.i_func_quiesced = 1'b1;
    goto(60);
    check("mid_no_cpl", evq.size(), 0);

    evq.delete();
    bus.flr_active_pf = 4'b0010;
    t0 = cyc;
    goto(24);
    check("post_rst_count", evq.size(), 1);
    chk_ev("post_rst_pf1", 0, pack(4'b0010, 1'b0, 2'd0, 11'd0), 19);
    bus.flr_active_pf = 4'b0000;
    goto(26);

    // Re-request on PF0 while it is in RESET
    evq.delete();
    bus.flr_active_pf = 4'b0001;
    t0 = cyc;
    goto(3); bus.flr_active_pf = 4'b0000;
    goto(4); bus.flr_active_pf = 4'b0001;
    goto(45);
    check("rereq_count", evq.size(), 2);
    chk_ev("rereq_first", 0, pack(4'b0001, 1'b0, 2'd0, 11'd0), 19);
    chk_ev("rereq_second", 1, pack(4'b0001, 1'b0, 2'd0, 11'd0), 38);
    bus.flr_active_pf = 4'b0000;
    goto(47);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_flr_responder.md
# pcie_flr_responder

FIM-side responder for PCIe Function Level Reset (FLR) on the fim_clk domain. It consumes PF FLR-active levels and VF FLR-received pulses from the PCIe FLR resync path, serialises them through one reset engine, and drives a function-reset request toward the port/AFU logic. Once the targeted function has quiesced, it returns the matching flr_completed_* pulse to the PCIe side. It is the completion end of the FLR handshake whose request end lives in the PCIe subsystem.

## Interface
Parameters:
- NUM_PF, 4: number of physical functions; width of the PF vectors
- PF_WIDTH, 2: PF number width
- VF_WIDTH, 11: VF number width
- RST_HOLD_CYCLES, 16: minimum cycles o_func_rst_valid is held before quiesce is checked; must be ≥1
- VF_FIFO_DEPTH, 4: VF request FIFO depth; power of two, ≥2

Ports:
- fim_clk  in  1  sole clock
- fim_rst_n  in  1  asynchronous, active-low reset
- flr_active_pf  in  NUM_PF  per-PF FLR-active level
- flr_rcvd_vf  in  1  single-cycle VF FLR request strobe
- flr_rcvd_pf_num  in  PF_WIDTH  parent PF of the VF request
- flr_rcvd_vf_num  in  VF_WIDTH  VF number of the request
- flr_completed_pf  out  NUM_PF  one-hot, single-cycle PF completion pulse
- flr_completed_vf  out  1  single-cycle VF completion pulse
- flr_completed_pf_num  out  PF_WIDTH  PF number for the VF completion
- flr_completed_vf_num  out  VF_WIDTH  VF number for the VF completion
- o_func_rst_valid  out  1  function reset asserted toward the port
- o_func_rst_vf_active  out  1  1 = the target is a VF
- o_func_rst_pf  out  PF_WIDTH  target PF
- o_func_rst_vf  out  VF_WIDTH  target VF; 0 when the target is a PF
- i_func_quiesced  in  1  port reports no outstanding traffic for the target
- o_vf_overflow  out  1  sticky: a VF request was dropped

## Operation
- PF capture: flr_active_pf is registered once; a rising edge on bit i sets pf_pending[i]. Levels and falling edges have no other effect.
- VF capture: when flr_rcvd_vf=1, {pf_num, vf_num} is pushed into the VF FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the request is dropped and o_vf_overflow is set.
  - A push to a full FIFO in the same cycle as a pop is accepted.
- Engine FSM: IDLE → RESET → DRAIN → DONE → IDLE.
  - IDLE: if any pf_pending bit is set, select the lowest-index pending PF and clear its bit. Otherwise, if the FIFO is not empty, pop its head. Either selection loads the target registers and moves to RESET. PF requests take priority over VF requests.
  - RESET: o_func_rst_valid=1. The counter runs RST_HOLD_CYCLES cycles, then the FSM moves to DRAIN.
  - DRAIN: o_func_rst_valid stays 1. The FSM waits until i_func_quiesced=1 is sampled, then moves to DONE. There is no timeout.
  - DONE: o_func_rst_valid=0. For a PF target, pulse flr_completed_pf[target]. For a VF target, pulse flr_completed_vf and drive the num outputs from the target. Return to IDLE.
- Re-request: a new rising edge on a PF that is in service sets its pending bit again, so that PF is serviced a second time after DONE.
- A PF request whose flr_active_pf level falls before completion is still completed.
- The target outputs hold their value from the IDLE exit through DONE.
- Reset: asynchronous clear of all state. The FSM returns to IDLE, the FIFO empties, pending bits clear and o_vf_overflow clears.
- Reset mid-operation: an in-flight FLR is abandoned with no completion pulse.

## Timing
- Reset values: all outputs 0.
- Cycle numbering: a request sampled at the edge ending cycle 0 produces:
  - pending or FIFO non-empty in cycle 1
  - RESET entered and o_func_rst_valid=1 in cycle 2
  - DRAIN in cycle 2+RST_HOLD_CYCLES
- If i_func_quiesced is already 1, DONE and the completion pulse occur in cycle 3+RST_HOLD_CYCLES. With the default, that is cycle 19.
- Back-to-back requests: the next IDLE exit occurs one cycle after DONE. Per-request occupancy is RST_HOLD_CYCLES+3 cycles minimum.
- All completion outputs are registered, last exactly one cycle, and are 0 outside DONE. Completion num outputs are 0 outside DONE.

## Test plan
- PF request:
  - Stimulus: rising edge on flr_active_pf[2], i_func_quiesced=1, defaults.
  - Expected: o_func_rst_valid high for cycles 2–18 with o_func_rst_pf=2 and vf_active=0; flr_completed_pf=4'b0100 for exactly one cycle in cycle 19.
- VF request with delayed quiesce:
  - Stimulus: flr_rcvd_vf pulse with pf=1, vf=0x2A; i_func_quiesced held 0 until cycle 40.
  - Expected: o_func_rst_valid held through cycle 40; flr_completed_vf pulse with pf_num=1, vf_num=0x2A at cycle 41.
- Priority:
  - Stimulus: in the same cycle, a VF pulse (pf 0, vf 5) plus rising edges on PF3 and PF1, quiesce tied high.
  - Expected: completions in the order PF1, PF3, VF5, spaced 19 cycles apart.
- FIFO overflow:
  - Stimulus: 6 VF pulses on consecutive cycles while the engine is busy with a PF.
  - Expected: 4 VF completions, in push order, after the PF completion; o_vf_overflow=1 and held until reset.
- Reset mid-operation:
  - Stimulus: assert fim_rst_n low during DRAIN, then release it.
  - Expected: all outputs 0 immediately on assertion; no completion pulse afterwards; a new PF edge is then serviced normally.
- Re-request:
  - Stimulus: a second rising edge on PF0 during RESET of PF0.
  - Expected: two PF0 completion pulses, 19 cycles apart.
